// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
//   Round-robin arbiter sharing the single write port of a 2**W x B register
//   file among N requesters. One write per cycle is accepted (combinational
//   grant) and forwarded to the register file through one register stage.
//
//   Optional feature macro: RF_ARB_INIT_EN
//     defined   - after every reset an INIT sequence zero-fills all 2**W
//                 entries (busy=1, no grants) before arbitration starts.
//     undefined - arbitration starts directly out of reset, busy tied to 0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester write request
//   req_lock   per-requester priority hold (only the granted one matters)
//   req_addr   flattened addresses, requester i at [i*W +: W]
//   req_data   flattened data, requester i at [i*B +: B]
//   gnt        one-hot combinational grant
//   busy       high while the INIT sequence runs
//   rf_wr_en   registered register-file write enable
//   rf_w_addr  registered register-file write address
//   rf_w_data  registered register-file write data
module rf_wr_arbiter #(
  parameter int B = 8,
  parameter int W = 2,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_lock,
  input  logic [N*W-1:0] req_addr,
  input  logic [N*B-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           rf_wr_en,
  output logic [W-1:0]   rf_w_addr,
  output logic [B-1:0]   rf_w_data
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          any;
  logic          run;
  logic          accept;
  int            idx;

`ifdef RF_ARB_INIT_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] cnt;

  assign run  = (state == ST_RUN);
  assign busy = (state == ST_INIT);
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Search ptr, ptr+1, ... modulo N; the first requester found wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int o = 0; o < N; o++) begin
      idx = (int'(ptr) + o) % N;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = PW'(idx);
      end
    end
  end

  // Gating with rst_n keeps gnt at 0 while reset is held.
  assign accept = any & run & rst_n;

  always_comb begin
    gnt = '0;
    if (accept) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      rf_wr_en  <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
`ifdef RF_ARB_INIT_EN
      state     <= ST_INIT;
      cnt       <= '0;
`endif
    end else begin
`ifdef RF_ARB_INIT_EN
      if (state == ST_INIT) begin
        // Zero-fill one entry per cycle; the last entry hands over to RUN.
        rf_wr_en  <= 1'b1;
        rf_w_addr <= cnt;
        rf_w_data <= '0;
        cnt       <= cnt + W'(1);
        if (cnt == {W{1'b1}}) state <= ST_RUN;
      end else
`endif
      if (accept) begin
        rf_wr_en  <= 1'b1;
        rf_w_addr <= req_addr[int'(win)*W +: W];
        rf_w_data <= req_data[int'(win)*B +: B];
        // A locked winner keeps top priority; otherwise rotate past it.
        if (req_lock[win])
          ptr <= win;
        else if (win == PW'(N-1))
          ptr <= '0;
        else
          ptr <= win + PW'(1);
      end else begin
        rf_wr_en <= 1'b0;
      end
    end
  end

endmodule
